// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered hsync/vsync/de, pixel coordinates and line/frame
// strobes, advancing one pixel per pix_ce. Sticky line-compare irq when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen #(
   parameter int CNT_W    = 11,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] hpos,
   output logic [CNT_W-1:0] vpos,
   output logic             line_start,
   output logic             frame_start,
   input  logic [CNT_W-1:0] irq_line,
   input  logic             irq_ack,
   output logic             irq
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_chk_h_seg
      $error("vga_timing_gen: every horizontal segment must be at least 1");
   end
   if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_v_seg
      $error("vga_timing_gen: every vertical segment must be at least 1");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_chk_total
      $error("vga_timing_gen: line or frame total does not fit in CNT_W bits");
   end

   // One extra bit so window ends equal to 2^CNT_W still compare correctly.
   typedef logic [CNT_W:0] ext_t;

   localparam ext_t H_LAST = ext_t'(H_TOTAL - 1);
   localparam ext_t V_LAST = ext_t'(V_TOTAL - 1);
   localparam ext_t H_ACT  = ext_t'(H_ACTIVE);
   localparam ext_t V_ACT  = ext_t'(V_ACTIVE);
   localparam ext_t HS_BEG = ext_t'(H_ACTIVE + H_FP);
   localparam ext_t HS_END = ext_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam ext_t VS_BEG = ext_t'(V_ACTIVE + V_FP);
   localparam ext_t VS_END = ext_t'(V_ACTIVE + V_FP + V_SYNC);

   ext_t hpos_e;
   ext_t vpos_e;
   ext_t h_nxt;
   ext_t v_nxt;
   logic h_wrap;
   logic v_wrap;

   always_comb begin
      hpos_e = {1'b0, hpos};
      vpos_e = {1'b0, vpos};
      h_wrap = (hpos_e == H_LAST);
      v_wrap = (vpos_e == V_LAST);
      h_nxt  = h_wrap ? '0 : hpos_e + ext_t'(1);
      v_nxt  = vpos_e;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : vpos_e + ext_t'(1);
      end
   end

   // Reset parks on the last pixel so the first strobe lands on (0,0) with both pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         hpos        <= H_LAST[CNT_W-1:0];
         vpos        <= V_LAST[CNT_W-1:0];
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_ce) begin
            hpos        <= h_nxt[CNT_W-1:0];
            vpos        <= v_nxt[CNT_W-1:0];
            hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : ~VS_POL;
            de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
         end
      end
   end

`ifdef VGA_TIMING_LINE_IRQ_EN
   logic irq_hit;

   // v_nxt never reaches V_TOTAL, so an out-of-range irq_line simply never matches.
   assign irq_hit = pix_ce && h_wrap && (v_nxt == {1'b0, irq_line});

   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (irq_hit) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`else
   logic unused_irq_inputs;

   assign unused_irq_inputs = ^{irq_line, irq_ack};
   assign irq               = 1'b0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the display path. It produces registered hsync/vsync, a data-enable signal, and pixel coordinates for any resolution, with configurable sync polarity and one-cycle line/frame start strobes. It runs on the system clock and advances one pixel per `pix_ce` strobe, instead of clocking on the enable. Downstream pixel generators and frame buffers index memory directly with `hpos`/`vpos`.

## Interface
- `CNT_W`, 11, width of the horizontal and vertical counters and of the position outputs
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)
- `clk` in 1: system clock; all logic on its rising edge
- `reset` in 1: reset, synchronous, active-high
- `pix_ce` in 1: pixel advance strobe, one `clk` wide
- `hsync` out 1: horizontal sync at `HS_POL` level when active
- `vsync` out 1: vertical sync at `VS_POL` level when active
- `de` out 1: high while the current pixel is visible
- `hpos` out `CNT_W`: horizontal counter, 0..H_TOTAL-1
- `vpos` out `CNT_W`: vertical counter, 0..V_TOTAL-1
- `line_start` out 1: one-`clk` pulse when `hpos` becomes 0
- `frame_start` out 1: one-`clk` pulse when (`hpos`,`vpos`) becomes (0,0)
- `irq_line` in `CNT_W`: line-compare value (see Configuration)
- `irq_ack` in 1: clears `irq`
- `irq` out 1: sticky line-compare interrupt

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Every segment must be ≥1, and both totals must be ≤2^CNT_W. The implementation checks these at elaboration.
- Horizontal segment order from count 0: active, front porch, sync, back porch. Vertical order is the same. Pixel (x,y) is therefore `hpos`=x, `vpos`=y while `de`=1.
- On `pix_ce`:
  - If `hpos`=H_TOTAL-1, `hpos` goes to 0.
  - Otherwise `hpos` increments by 1.
  - `vpos` increments only when `hpos` wraps. If `vpos` is also V_TOTAL-1 at that point, it wraps to 0.
- Without `pix_ce`, all outputs hold, except `line_start` and `frame_start`, which return to 0.
- `hsync` is active when H_ACTIVE+H_FP ≤ `hpos` < H_ACTIVE+H_FP+H_SYNC.
- `vsync` is active when V_ACTIVE+V_FP ≤ `vpos` < V_ACTIVE+V_FP+V_SYNC. `vsync` edges coincide with `hpos`=0.
- `de` = (`hpos` < H_ACTIVE) and (`vpos` < V_ACTIVE).
- `hsync`, `vsync`, `de`, `line_start` and `frame_start` are registers, computed from the next counter values. They are therefore cycle-aligned with `hpos`/`vpos`, with no combinational path from the counters.

## Timing
- Reset values:
  - `hpos`=H_TOTAL-1, `vpos`=V_TOTAL-1
  - `hsync`=!HS_POL, `vsync`=!VS_POL, `de`=0
  - `line_start`=0, `frame_start`=0, `irq`=0
- Because reset parks the counters on the last pixel, the first `pix_ce` after reset loads (0,0) and raises `line_start` and `frame_start`.
- Latency: outputs update at the same `clk` edge that samples `pix_ce`=1.
- `reset` overrides `pix_ce` on the same edge.
- Reset mid-frame returns every output to its reset value on the next edge, and any pending pulse is dropped.
- `pix_ce` held high continuously advances one pixel per `clk`.
- `line_start` and `frame_start` are high for exactly one `clk`, even if `pix_ce` is high on the following cycle.

## Configuration
- Macro: `VGA_TIMING_LINE_IRQ_EN`.
- Defined:
  - `irq` is set on the `pix_ce` edge that wraps `hpos` to 0 with the new `vpos` equal to `irq_line`.
  - `irq` stays high until an edge with `irq_ack`=1.
  - If set and ack occur on the same edge, set wins.
  - An `irq_line` ≥ V_TOTAL never fires.
- Undefined: the ports remain, `irq` is constant 0, and `irq_line`/`irq_ack` are ignored.

## Test plan
Small timing for simulation: H = 8/2/3/2 (total 15), V = 4/1/2/1 (total 8), `pix_ce` every other `clk`.

- Reset, then first `pix_ce` → `hpos`=0, `vpos`=0, `line_start`=1, `frame_start`=1, `de`=1; both pulses drop one `clk` later.
- Full frame of 120 strobes:
  - `hsync` low exactly for `hpos` 10..12 on every line.
  - `vsync` low exactly for `vpos` 5..6.
  - `de` high for 32 strobes.
  - 8 `line_start` pulses and 1 `frame_start` pulse.
- HS_POL=1, VS_POL=1 → sync windows unchanged but inverted; reset levels are 0.
- Reset asserted at `hpos`=5, `vpos`=2 with `pix_ce`=1 → next edge `hpos`=14, `vpos`=7, `de`=0; the next `pix_ce` gives `frame_start`.
- Macro on, `irq_line`=3 → `irq` rises with `hpos`=0, `vpos`=3. `irq_ack` pulsed on the same edge as a later set leaves `irq`=1. A lone ack clears it. `irq_line`=9 never fires.
